// File: rtl/rf_read.sv
// Beta register-fetch stage: 31-entry register file (R31 hard-wired zero),
// ALU/MEM/WB operand forwarding, load-use interlock and RF->ALU pipeline register.
module rf_read #(
  parameter logic [31:0] NOP_INSTR = 32'hC3FF0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ir,
  input  logic [31:0] pc,
  input  logic        ra2sel,
  input  logic        flush,
  input  logic        alu_we,
  input  logic [4:0]  alu_waddr,
  input  logic [31:0] alu_y,
  input  logic        alu_is_ld,
  input  logic        mem_we,
  input  logic [4:0]  mem_waddr,
  input  logic [31:0] mem_y,
  input  logic        mem_is_ld,
  input  logic        rf_w_en,
  input  logic [4:0]  rf_w_addr,
  input  logic [31:0] rf_w_data,
  output logic        stall,
  output logic [31:0] a_alu,
  output logic [31:0] b_alu,
  output logic [31:0] ir_alu,
  output logic [31:0] pc_alu
);

  localparam logic [4:0] R31 = 5'd31;

  typedef struct packed {
    logic [31:0] data;
    logic        ld_hit;
  } operand_t;

  logic [31:0] regs_q [31];

  logic [4:0]  ra_addr;
  logic [4:0]  rb_addr;
  logic [31:0] ra_arr;
  logic [31:0] rb_arr;
  operand_t    opa;
  operand_t    opb;

  logic [31:0] a_q,  a_d;
  logic [31:0] b_q,  b_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] pc_q, pc_d;

  // First matching source wins; a hit on a load stage means the data is not
  // yet available, so the caller must interlock rather than use it.
  function automatic operand_t select_operand(
    input logic [4:0]  addr,
    input logic [31:0] arr_val,
    input logic        a_we,  input logic [4:0] a_wa, input logic [31:0] a_y, input logic a_ld,
    input logic        m_we,  input logic [4:0] m_wa, input logic [31:0] m_y, input logic m_ld,
    input logic        w_en,  input logic [4:0] w_wa, input logic [31:0] w_d
  );
    operand_t r;
    r = '0;
    if (addr == R31) begin
      r.data   = '0;
      r.ld_hit = 1'b0;
    end else if (a_we && a_wa == addr) begin
      r.data   = a_y;
      r.ld_hit = a_ld;
    end else if (m_we && m_wa == addr) begin
      r.data   = m_y;
      r.ld_hit = m_ld;
    end else if (w_en && w_wa == addr) begin
      r.data   = w_d;
      r.ld_hit = 1'b0;
    end else begin
      r.data   = arr_val;
      r.ld_hit = 1'b0;
    end
    return r;
  endfunction

  always_comb begin
    ra_addr = ir[20:16];
    rb_addr = ra2sel ? ir[25:21] : ir[15:11];
    ra_arr  = (ra_addr == R31) ? '0 : regs_q[ra_addr];
    rb_arr  = (rb_addr == R31) ? '0 : regs_q[rb_addr];
  end

  always_comb begin
    opa = select_operand(ra_addr, ra_arr,
                         alu_we, alu_waddr, alu_y, alu_is_ld,
                         mem_we, mem_waddr, mem_y, mem_is_ld,
                         rf_w_en, rf_w_addr, rf_w_data);
    opb = select_operand(rb_addr, rb_arr,
                         alu_we, alu_waddr, alu_y, alu_is_ld,
                         mem_we, mem_waddr, mem_y, mem_is_ld,
                         rf_w_en, rf_w_addr, rf_w_data);
  end

  assign stall = ~flush & (opa.ld_hit | opb.ld_hit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 31; i++) begin
        regs_q[i] <= '0;
      end
    end else if (rf_w_en && rf_w_addr != R31) begin
      regs_q[rf_w_addr] <= rf_w_data;
    end
  end

  always_comb begin
    pc_d = pc;
    ir_d = ir;
    a_d  = opa.data;
    b_d  = opb.data;
    if (flush || stall) begin
      ir_d = NOP_INSTR;
      a_d  = '0;
      b_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir_q <= NOP_INSTR;
      a_q  <= '0;
      b_q  <= '0;
      pc_q <= '0;
    end else begin
      ir_q <= ir_d;
      a_q  <= a_d;
      b_q  <= b_d;
      pc_q <= pc_d;
    end
  end

  assign a_alu  = a_q;
  assign b_alu  = b_q;
  assign ir_alu = ir_q;
  assign pc_alu = pc_q;

endmodule
